// File: rtl/sersub_pkg.sv
// -----------------------------------------------------------------------------
// sersub_pkg
// Shared declarations for the bit-serial subtractor slice.
//   sersub_state_e : controller states (IDLE, RUN, DONE)
//   SERSUB_W       : default operand/result width
// -----------------------------------------------------------------------------
package sersub_pkg;

   localparam int SERSUB_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sersub_state_e;

endpackage : sersub_pkg

// File: rtl/sersub_if.sv
// -----------------------------------------------------------------------------
// sersub_if
// Start/busy/done operand/result bundle between a controller and sersub.
//   start, x, y, bi : request and operands (controller -> subtractor)
//   busy, done      : progress / one-cycle completion pulse
//   d, bo           : difference and borrow-out, held until next accepted start
//   ovf             : signed overflow, present only with SERSUB_OVF_EN defined
//
// Handshake: start is sampled on a rising edge only while busy is low; that
// edge captures x, y and bi. done is high for exactly one cycle and d/bo/ovf
// are valid for as long as no new start is accepted. There is no back-pressure
// and no queuing: a start seen while busy is dropped.
//
// Modports: master = controller side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface sersub_if
   import sersub_pkg::*;
#(
   parameter int W = SERSUB_W
);

   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         bi;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bo;
`ifdef SERSUB_OVF_EN
   logic         ovf;
`endif

   modport master (
      output start, x, y, bi,
      input  busy, done, d, bo
`ifdef SERSUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, x, y, bi,
      output busy, done, d, bo
`ifdef SERSUB_OVF_EN
      , output ovf
`endif
   );

endinterface : sersub_if

// File: rtl/sersub_fsc.sv
// -----------------------------------------------------------------------------
// sersub_fsc
// Combinational one-bit full-subtractor cell: diff = a - b - bin.
//   a, b, bin  : minuend bit, subtrahend bit, borrow-in
//   diff, bout : difference bit, borrow-out
// -----------------------------------------------------------------------------
module sersub_fsc (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   // Borrow when b exceeds a outright, or when a == b and a borrow arrives.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : sersub_fsc

// File: rtl/sersub.sv
// -----------------------------------------------------------------------------
// sersub
// Bit-serial W-bit subtractor, d = x - y - bi, one bit per clock, LSB first.
// One full-subtractor cell plus a registered borrow replace a ripple chain.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : sersub_if.slave (start/x/y/bi in, busy/done/d/bo[/ovf] out)
//   dbg_state : current controller state, for observation only
//
// Optional feature: define SERSUB_OVF_EN to add the ovf output and the
// captured-operand MSB registers it needs.
//
// Timing: start accepted at edge 0, bits 0..W-1 produced at edges 1..W,
// done high after edge W for one cycle. d shows partial shifts while busy.
// -----------------------------------------------------------------------------
module sersub
   import sersub_pkg::*;
#(
   parameter int W = SERSUB_W
) (
   input  logic          clk,
   input  logic          rst_n,
   sersub_if.slave       bus,
   output sersub_state_e dbg_state
);

   localparam int CW = $clog2(W);

   sersub_state_e state_q, state_d;

   logic [W-1:0]  xs_q;
   logic [W-1:0]  ys_q;
   logic [W-1:0]  d_q;
   logic          borrow_q;
   logic          bo_q;
   logic [CW-1:0] cnt_q;

   logic          accept;
   logic          last_bit;
   logic          cell_diff;
   logic          cell_bout;

`ifdef SERSUB_OVF_EN
   logic          x_msb_q;
   logic          y_msb_q;
   logic          ovf_q;
`endif

   // A request is taken in IDLE and also in DONE, which gives back-to-back
   // operation with no idle cycle when start is held.
   assign accept   = bus.start && (state_q != RUN);
   assign last_bit = (state_q == RUN) && (cnt_q == CW'(W - 1));

   sersub_fsc u_fsc (
      .a    (xs_q[0]),
      .b    (ys_q[0]),
      .bin  (borrow_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = RUN;
         end
         RUN: begin
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            state_d = accept ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xs_q     <= '0;
         ys_q     <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         bo_q     <= 1'b0;
         cnt_q    <= '0;
`ifdef SERSUB_OVF_EN
         x_msb_q  <= 1'b0;
         y_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else if (accept) begin
         xs_q     <= bus.x;
         ys_q     <= bus.y;
         borrow_q <= bus.bi;
         cnt_q    <= '0;
`ifdef SERSUB_OVF_EN
         // Shift registers lose the MSBs, so keep them for the overflow test.
         x_msb_q  <= bus.x[W-1];
         y_msb_q  <= bus.y[W-1];
`endif
      end else if (state_q == RUN) begin
         // New bit enters at the top; after W shifts bit 0 sits at d[0].
         d_q      <= {cell_diff, d_q[W-1:1]};
         xs_q     <= {1'b0, xs_q[W-1:1]};
         ys_q     <= {1'b0, ys_q[W-1:1]};
         borrow_q <= cell_bout;
         cnt_q    <= cnt_q + CW'(1);
         if (last_bit) begin
            bo_q  <= cell_bout;
`ifdef SERSUB_OVF_EN
            // cell_diff here is the final d[W-1].
            ovf_q <= (x_msb_q != y_msb_q) && (cell_diff != x_msb_q);
`endif
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.d    = d_q;
   assign bus.bo   = bo_q;
`ifdef SERSUB_OVF_EN
   assign bus.ovf  = ovf_q;
`endif
   assign dbg_state = state_q;

endmodule : sersub
